// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and datapath-select encodings for the multi-cycle controller
// Also holds the per-state control decode used by mc_main_fsm.
package mc_pkg;
   localparam int WAIT_MAX_DEF = 64;
   localparam int CNT_W_DEF    = 7;
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_FPUEXEC  = 4'd10,
      S_MULEXEC  = 4'd11,
      S_XWB      = 4'd12
   } state_t;
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_FPU = 2'b11;
   localparam logic [1:0] SRCA_RN     = 2'b00;
   localparam logic [1:0] SRCA_PC     = 2'b01;
   localparam logic [1:0] SRCA_ALUOUT = 2'b10;
   localparam logic [1:0] SRCB_RM     = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;
   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_DATA    = 2'b01;
   localparam logic [1:0] RES_ALURES  = 2'b10;
   localparam logic [1:0] RES_X       = 2'b11;
   typedef struct packed {
      logic       ir_write;
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
   } ctrl_t;
   function automatic ctrl_t ctrl_of(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.ir_write   = 1'b1;
            c.next_pc    = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURES;
         end
         S_DECODE: begin
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURES;
         end
         S_MEMADR:   c.alu_src_b = SRCB_IMM;
         S_MEMREAD: begin
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_w      = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src = 1'b1;
            c.mem_w   = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_src_b = SRCB_RM;
            c.alu_op    = 1'b1;
         end
         S_EXECUTEI: begin
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = 1'b1;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_w      = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_b  = SRCB_IMM;
            c.result_src = RES_ALURES;
            c.branch     = 1'b1;
         end
         S_XWB: begin
            c.result_src = RES_X;
            c.reg_w      = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction
endpackage

// File: rtl/mc_main_fsm_if.sv
// mc_main_fsm_if: instruction/handshake inputs and datapath control outputs of the main sequencer
// slave modport: the sequencer (consumes op/funct/is_mul/done, drives controls)
// master modport: the surrounding controller/datapath
interface mc_main_fsm_if;
   logic [1:0] op;
   logic [5:0] funct;
   logic       is_mul;
   logic       fpu_done;
   logic       mul_done;
   logic       ir_write;
   logic       adr_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic       next_pc;
   logic       reg_w;
   logic       mem_w;
   logic       branch;
   logic       alu_op;
   logic       fpu_start;
   logic       mul_start;
   logic       wait_err;
   logic [3:0] state;
   modport slave (
      input  op, funct, is_mul, fpu_done, mul_done,
      output ir_write, adr_src, alu_src_a, alu_src_b, result_src, next_pc,
             reg_w, mem_w, branch, alu_op, fpu_start, mul_start, wait_err, state
   );
   modport master (
      output op, funct, is_mul, fpu_done, mul_done,
      input  ir_write, adr_src, alu_src_a, alu_src_b, result_src, next_pc,
             reg_w, mem_w, branch, alu_op, fpu_start, mul_start, wait_err, state
   );
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: watchdog counter shared by the FPU and multiply wait states
// clk, rst_n (async active-low); i_clr zeroes the count, i_en counts up;
// o_expired is high while the count sits at WAIT_MAX-1.
module mc_wait_timer #(
   parameter int WAIT_MAX = 64,
   parameter int CNT_W    = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else r_cnt <= i_clr ? '0 : i_en ? r_cnt + 1'b1 : r_cnt;
   assign o_expired = r_cnt == CNT_W'(WAIT_MAX - 1);
endmodule

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: Moore sequencer of the multi-cycle ARM datapath with FPU/MUL wait handshakes
// clk, rst_n (async active-low); bus (mc_main_fsm_if.slave): op, funct, is_mul,
// fpu_done, mul_done in; registered mux selects, strobes, fpu/mul start pulses,
// sticky wait_err and the state code out.
// MC_MUL_EN: when defined, multiplies go through MULEXEC; otherwise is_mul and
// mul_done are ignored, mul_start stays 0 and multiplies run as EXECUTER.
module mc_main_fsm
   import mc_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   mc_main_fsm_if.slave  bus
);
   state_t r_state, w_next;
   ctrl_t  r_ctrl;
   logic   r_primed, r_fpu_start, r_mul_start, r_wait_err;
   logic   w_is_mul, w_waiting, w_expired;
   logic   w_unused_funct;
   assign w_unused_funct = ^bus.funct[4:1];
`ifdef MC_MUL_EN
   assign w_is_mul = bus.is_mul;
`else
   logic w_unused_mul;
   assign w_unused_mul = bus.is_mul ^ bus.mul_done;
   assign w_is_mul     = 1'b0;
`endif
   assign w_waiting = r_state == S_FPUEXEC || r_state == S_MULEXEC;
   // held at zero outside the wait states, so the first wait cycle always reads 0
   mc_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (!w_waiting),
      .i_en      (w_waiting),
      .o_expired (w_expired)
   );
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         // reset parks in FETCH with strobes off; the first edge loads FETCH's controls
         S_FETCH:    w_next = r_primed ? S_DECODE : S_FETCH;
         S_DECODE:   w_next = bus.op == OP_MEM ? S_MEMADR :
                              bus.op == OP_BR  ? S_BRANCH :
                              bus.op == OP_FPU ? S_FPUEXEC :
                              bus.funct[5]     ? S_EXECUTEI :
                              w_is_mul         ? S_MULEXEC : S_EXECUTER;
         S_MEMADR:   w_next = bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         // done beats a coincident timeout
         S_FPUEXEC:  w_next = bus.fpu_done ? S_XWB : w_expired ? S_FETCH : S_FPUEXEC;
`ifdef MC_MUL_EN
         S_MULEXEC:  w_next = bus.mul_done ? S_XWB : w_expired ? S_FETCH : S_MULEXEC;
`endif
         default:    w_next = S_FETCH;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_ctrl      <= '0;
         r_primed    <= 1'b0;
         r_fpu_start <= 1'b0;
         r_mul_start <= 1'b0;
         r_wait_err  <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_ctrl      <= ctrl_of(w_next);
         r_primed    <= 1'b1;
         r_fpu_start <= w_next == S_FPUEXEC && r_state != S_FPUEXEC;
         r_mul_start <= w_next == S_MULEXEC && r_state != S_MULEXEC;
         r_wait_err  <= r_wait_err | (w_waiting && w_next == S_FETCH);
      end
   assign bus.ir_write   = r_ctrl.ir_write;
   assign bus.adr_src    = r_ctrl.adr_src;
   assign bus.alu_src_a  = r_ctrl.alu_src_a;
   assign bus.alu_src_b  = r_ctrl.alu_src_b;
   assign bus.result_src = r_ctrl.result_src;
   assign bus.next_pc    = r_ctrl.next_pc;
   assign bus.reg_w      = r_ctrl.reg_w;
   assign bus.mem_w      = r_ctrl.mem_w;
   assign bus.branch     = r_ctrl.branch;
   assign bus.alu_op     = r_ctrl.alu_op;
   assign bus.fpu_start  = r_fpu_start;
   assign bus.mul_start  = r_mul_start;
   assign bus.wait_err   = r_wait_err;
   assign bus.state      = r_state;
endmodule
